aes_inv_cipher: RTL and testbench



---
 rtl/aes_pkg.sv | 78 +++++++
 rtl/aes_inv_cipher_if.sv | 15 +
 rtl/aes_inv_round.sv | 38 +++
 rtl/aes_inv_cipher.sv | 136 +++++++++++++
 tb/tb_aes_inv_cipher.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, S-box tables, round constants, GF(2^8) helpers and the
// controller state enum used by the iterative inverse cipher.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_e;

    // Byte 0 of each table sits in the top 8 bits.
    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_T = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic byte_t sbox(input byte_t x);
        return SBOX_T[{~x, 3'b111} -: 8];
    endfunction

    function automatic byte_t inv_sbox(input byte_t x);
        return INV_SBOX_T[{~x, 3'b111} -: 8];
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic byte_t rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// Start/done request interface of the inverse cipher: the requester drives
// start/key/ciphertext, the core returns ready/done/plaintext.
interface aes_inv_cipher_if;
    import aes_pkg::*;

    logic   start;
    block_t key;
    block_t ciphertext;
    logic   ready;
    logic   done;
    block_t plaintext;

    modport master (output start, key, ciphertext, input ready, done, plaintext);
    modport slave  (input start, key, ciphertext, output ready, done, plaintext);
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  block_t state_i,
    input  block_t rk_i,
    input  logic   last_i,
    output block_t state_o
);

    localparam byte_t IMC [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    // Byte n of the block lives at index 15-n; byte n is row n%4 of column n/4.
    byte_t [15:0] in_b, rk_b, ark_b, mix_b;

    assign in_b = state_i;
    assign rk_b = rk_i;

    for (genvar n = 0; n < 16; n++) begin : g_byte
        localparam int C   = n / 4;
        localparam int R   = n % 4;
        localparam int SRC = 4 * ((C - R + 4) % 4) + R;
        assign ark_b[15-n] = inv_sbox(in_b[15-SRC]) ^ rk_b[15-n];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign mix_b[15-(4*c+r)] = gf_mul(ark_b[15-4*c],     IMC[(4-r)%4])
                                     ^ gf_mul(ark_b[15-(4*c+1)], IMC[(5-r)%4])
                                     ^ gf_mul(ark_b[15-(4*c+2)], IMC[(6-r)%4])
                                     ^ gf_mul(ark_b[15-(4*c+3)], IMC[(7-r)%4]);
        end
    end

    assign state_o = last_i ? ark_b : mix_b;

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption: forward key expansion to rk10, then ten inverse
// rounds unwinding the key schedule. Optional AES_INV_KEY_CACHE_EN skips expansion.
module aes_inv_cipher
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic            clk,
    input  logic            rst,
    aes_inv_cipher_if.slave bus
);

    if (NR != 10) begin : g_nr_check
        $error("aes_inv_cipher: NR must be 10 for AES-128");
    end

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_e     fsm_q;
    logic [3:0] rnd_q;
    block_t     state_q, key_q, pt_q;
    logic       ready_q, done_q;
    block_t     rk_next_d, rk_prev_d, round_d;
    byte_t      rc_d;

    function automatic block_t next_rk(input block_t k, input byte_t rc);
        word_t w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic block_t reverse_rk(input block_t k, input byte_t rc);
        word_t v0, v1, v2, v3;
        v3 = k[31:0]  ^ k[63:32];
        v2 = k[63:32] ^ k[95:64];
        v1 = k[95:64] ^ k[127:96];
        v0 = k[127:96] ^ sub_word({v3[23:0], v3[31:24]}) ^ {rc, 24'h0};
        return {v0, v1, v2, v3};
    endfunction

    assign rc_d      = rcon(rnd_q);
    assign rk_next_d = next_rk(key_q, rc_d);
    assign rk_prev_d = reverse_rk(key_q, rc_d);

    aes_inv_round u_round (
        .state_i (state_q),
        .rk_i    (rk_prev_d),
        .last_i  (rnd_q == 4'd1),
        .state_o (round_d)
    );

`ifdef AES_INV_KEY_CACHE_EN
    logic   cache_vld_q, hit_d;
    block_t cache_key_q, cache_rk_q;

    assign hit_d = cache_vld_q && (bus.key == cache_key_q);

    // A miss invalidates the entry at capture; it is revalidated once rk10 exists.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q <= 1'b0;
        end else if (fsm_q == IDLE && ready_q && bus.start && !hit_d) begin
            cache_vld_q <= 1'b0;
            cache_key_q <= bus.key;
        end else if (fsm_q == KEXP && rnd_q == LAST_RND) begin
            cache_vld_q <= 1'b1;
            cache_rk_q  <= rk_next_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            rnd_q   <= '0;
            state_q <= '0;
            key_q   <= '0;
            pt_q    <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    if (ready_q && bus.start) begin
                        ready_q <= 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
                        if (hit_d) begin
                            key_q   <= cache_rk_q;
                            state_q <= bus.ciphertext ^ cache_rk_q;
                            rnd_q   <= LAST_RND;
                            fsm_q   <= ROUND;
                        end else
`endif
                        begin
                            key_q   <= bus.key;
                            state_q <= bus.ciphertext;
                            rnd_q   <= 4'd1;
                            fsm_q   <= KEXP;
                        end
                    end
                end
                KEXP: begin
                    key_q <= rk_next_d;
                    if (rnd_q == LAST_RND) begin
                        state_q <= state_q ^ rk_next_d;
                        fsm_q   <= ROUND;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                ROUND: begin
                    state_q <= round_d;
                    key_q   <= rk_prev_d;
                    rnd_q   <= rnd_q - 4'd1;
                    if (rnd_q == 4'd1) fsm_q <= DONE;
                end
                DONE: begin
                    pt_q   <= state_q;
                    done_q <= 1'b1;
                    fsm_q  <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.plaintext = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboard bench for aes_inv_cipher: directed FIPS-197 vectors, busy-start
// rejection, mid-operation reset and reset/start collision.
module tb_aes_inv_cipher;

    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_INV_KEY_CACHE_EN
    localparam int LAT_HIT = 11;
`else
    localparam int LAT_HIT = 21;
`endif

    typedef struct {
        logic [127:0] pt;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic pulse_chk = 1'b0;
    exp_t sb[$];

    aes_inv_cipher_if bus();

    aes_inv_cipher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor: every done pops one expectation; a done with nothing queued is an error.
    always @(negedge clk) begin
        if (pulse_chk) begin
            chk("done_single_cycle", {127'b0, bus.done}, 128'd0);
            pulse_chk = 1'b0;
        end
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done got=1 exp=0 at cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("plaintext", bus.plaintext, e.pt);
                chk("done_cycle", 128'(cyc), 128'(e.cyc));
            end
            pulse_chk = 1'b1;
        end
    end

    // Called at a negedge with ready=1; returns at the negedge after acceptance.
    task automatic issue(input logic [127:0] k, input logic [127:0] ct,
                         input logic [127:0] pt, input int lat, input bit push);
        exp_t e;
        bus.start      = 1'b1;
        bus.key        = k;
        bus.ciphertext = ct;
        if (push) begin
            e.pt  = pt;
            e.cyc = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {127'b0, bus.ready}, 128'd1);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.key        = '0;
        bus.ciphertext = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {127'b0, bus.ready}, 128'd1);
        chk("rst_done",  {127'b0, bus.done},  128'd0);
        chk("rst_pt",    bus.plaintext,       128'd0);
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 C.1 and B vectors
        issue(K_C1, CT_C1, PT_C1, 21, 1'b1);
        wait_ready();
        chk("pt_hold_c1", bus.plaintext, PT_C1);
        issue(K_B, CT_B, PT_B, 21, 1'b1);
        wait_ready();

        // start held high with junk while busy: only the first request counts
        issue(K_C1, CT_C1, PT_C1, 21, 1'b1);
        bus.start = 1'b1;
        bus.key        = {$urandom, $urandom, $urandom, $urandom};
        bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            chk($sformatf("busy_ready_c%0d", k), {127'b0, bus.ready}, 128'd0);
            bus.key        = {$urandom, $urandom, $urandom, $urandom};
            bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_ready_c22", {127'b0, bus.ready}, 128'd1);
        repeat (5) @(negedge clk);

        // reset during ROUND r=5 (cycle 15 after acceptance)
        wait_ready();
        issue(K_B, CT_B, PT_B, 21, 1'b0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", {127'b0, bus.ready}, 128'd1);
        chk("midrst_done",  {127'b0, bus.done},  128'd0);
        chk("midrst_pt",    bus.plaintext,       128'd0);
        @(negedge clk);
        issue(K_C1, CT_C1, PT_C1, 21, 1'b1);
        wait_ready();

        // start coinciding with reset is dropped
        rst            = 1'b1;
        bus.start      = 1'b1;
        bus.key        = K_C1;
        bus.ciphertext = CT_C1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        for (int k = 0; k < 30; k += 5) begin
            chk($sformatf("rststart_ready_%0d", k), {127'b0, bus.ready}, 128'd1);
            repeat (5) @(negedge clk);
        end

        // repeated key: second request may hit the key cache
        issue(K_C1, CT_C1, PT_C1, 21, 1'b1);
        wait_ready();
        issue(K_C1, CT_C1, PT_C1, LAT_HIT, 1'b1);
        wait_ready();
        issue(K_B, CT_B, PT_B, 21, 1'b1);
        wait_ready();
        repeat (5) @(negedge clk);

        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
